// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_if
//  Description : Request/result bundle between the EX stage and the divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             annul;
    logic             stall;
    logic             valid;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, signed_div, a, b, annul,
        input  stall, valid, hi_out, lo_out
    );

    modport slave (
        input  start, signed_div, a, b, annul,
        output stall, valid, hi_out, lo_out
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative radix-2 restoring divider for MIPS DIV/DIVU (HI/LO).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   rem_q,   rem_d;
    logic [WIDTH-1:0]   quo_q,   quo_d;
    logic [WIDTH-1:0]   dabs_q,  dabs_d;
    logic               neg_q,   neg_d;
    logic               rsgn_q,  rsgn_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     trial;
    logic               accept;

    assign a_neg  = bus.signed_div & bus.a[WIDTH-1];
    assign b_neg  = bus.signed_div & bus.b[WIDTH-1];
    assign a_abs  = a_neg ? ('0 - bus.a) : bus.a;
    assign b_abs  = b_neg ? ('0 - bus.b) : bus.b;
    assign accept = bus.start & ~bus.annul;

    // Shifted partial remainder (one extra bit) minus divisor magnitude.
    assign trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, dabs_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dabs_q  <= '0;
            neg_q   <= 1'b0;
            rsgn_q  <= 1'b0;
            valid_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dabs_q  <= dabs_d;
            neg_q   <= neg_d;
            rsgn_q  <= rsgn_d;
            valid_q <= valid_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dabs_d  = dabs_q;
        neg_d   = neg_q;
        rsgn_d  = rsgn_q;
        valid_d = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.b == '0) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        hi_d    = bus.a;
                        lo_d    = '1;
                    end else begin
                        state_d = S_DIV;
                        count_d = '0;
                        rem_d   = '0;
                        quo_d   = a_abs;
                        dabs_d  = b_abs;
                        neg_d   = a_neg ^ b_neg;
                        rsgn_d  = a_neg;
                    end
                end
            end
            S_DIV: begin
                if (bus.annul) begin
                    state_d = S_IDLE;
                end else begin
                    // Restore by keeping the shifted value when the trial underflows.
                    rem_d   = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]}
                                           : trial[WIDTH-1:0];
                    quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (bus.annul) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    hi_d    = rsgn_q ? ('0 - rem_q) : rem_q;
                    lo_d    = neg_q  ? ('0 - quo_q) : quo_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.stall  = ((state_q == S_IDLE) & accept) |
                        (state_q == S_DIV) |
                        (state_q == S_FIX);
    assign bus.valid  = valid_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Scoreboard bench for div_unit against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;
    localparam int W = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W), .CNT_W(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          vcyc;
        int          stalls;
    } exp_t;

    exp_t        exp_q[$];
    int          passed    = 0;
    int          total     = 0;
    int          vcount    = 0;
    int          stall_cnt = 0;
    logic [31:0] last_hi   = '0;
    logic [31:0] last_lo   = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic s, int n);
        exp_t   e;
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            e.hi = a; e.lo = 32'hFFFF_FFFF; e.vcyc = n + 1; e.stalls = 1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
            q = sa / sb;
            r = sa % sb;
            e.lo = q[31:0]; e.hi = r[31:0]; e.vcyc = n + 34; e.stalls = 34;
        end
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                stall_cnt = 0;
            end else if (bus.valid) begin
                vcount++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("lo_out", bus.lo_out, e.lo);
                    chk("hi_out", bus.hi_out, e.hi);
                    chk("valid_cycle", cyc, e.vcyc);
                    chk("stall_cycles", stall_cnt, e.stalls);
                    chk("stall_in_done", {31'd0, bus.stall}, 32'd0);
                end
                stall_cnt = 0;
            end else if (bus.annul) begin
                stall_cnt = 0;
            end else if (bus.stall) begin
                stall_cnt++;
            end
        end
    endtask

    task automatic kick(logic [31:0] a, logic [31:0] b, logic s);
        @(posedge clk); #2;
        bus.a = a; bus.b = b; bus.signed_div = s; bus.start = 1'b1;
    endtask

    task automatic scramble_inputs();
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.signed_div = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_q.size() != 0 && k < 120) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("result_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic run_op(logic [31:0] a, logic [31:0] b, logic s);
        exp_t e;
        kick(a, b, s);
        e = model(a, b, s, cyc);
        exp_q.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
        scramble_inputs();
        wait_done();
    endtask

    initial begin
        int          n;
        int          v0;
        logic [31:0] ra, rb;
        exp_t        e;

        bus.start = 1'b0; bus.annul = 1'b0; bus.signed_div = 1'b0;
        bus.a = '0; bus.b = '0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid",  {31'd0, bus.valid}, 32'd0);
        chk("reset_stall",  {31'd0, bus.stall}, 32'd0);
        chk("reset_hi",     bus.hi_out, 32'd0);
        chk("reset_lo",     bus.lo_out, 32'd0);
        @(posedge clk); #2 resetn = 1'b1;

        run_op(32'd100,        32'd7,          1'b0);
        run_op(32'hFFFF_FF9C,  32'd7,          1'b1);
        run_op(32'd100,        32'hFFFF_FFF9,  1'b1);
        run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1);
        run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b0);
        run_op(32'h0000_1234,  32'd0,          1'b0);
        run_op(32'hFFFF_1234,  32'd0,          1'b1);

        // Annul while iterating: count==10 lands in cycle n+11.
        kick(32'd1000, 32'd3, 1'b0);
        n  = cyc;
        v0 = vcount;
        scramble_inputs();
        repeat (10) @(posedge clk);
        #2 bus.annul = 1'b1;
        @(posedge clk); #2 bus.annul = 1'b0;
        @(negedge clk);
        chk("annul_idle_stall", {31'd0, bus.stall}, 32'd0);
        chk("annul_cycle", cyc, n + 12);
        chk("annul_hi_kept", bus.hi_out, last_hi);
        chk("annul_lo_kept", bus.lo_out, last_lo);
        repeat (40) @(negedge clk);
        chk("annul_no_valid", vcount, v0);
        run_op(32'd12345, 32'd10, 1'b0);

        // Reset in the middle of an operation.
        v0 = vcount;
        kick(32'd5000, 32'd7, 1'b1);
        scramble_inputs();
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_mid_hi",    bus.hi_out, 32'd0);
        chk("rst_mid_lo",    bus.lo_out, 32'd0);
        chk("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #2 resetn = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_no_valid", vcount, v0);
        run_op(32'hFFFF_FC18, 32'd9, 1'b1);

        // Back-to-back with start held high through DONE.
        ra = $urandom;
        rb = $urandom | 32'd1;
        kick(ra, rb, 1'b0);
        n = cyc;
        exp_q.push_back(model(ra, rb, 1'b0, n));
        ra = $urandom;
        rb = $urandom_range(1, 1000);
        @(posedge clk); #2;
        bus.a = ra; bus.b = rb; bus.signed_div = 1'b1;
        e = model(ra, rb, 1'b1, n + 35);
        exp_q.push_back(e);
        repeat (35) @(posedge clk);
        #2 bus.start = 1'b0;
        wait_done();
        last_hi = e.hi;
        last_lo = e.lo;

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            if (i % 7 == 3)                    rb = 32'd0;
            else if ($urandom_range(0, 2) == 0) rb = $urandom_range(1, 15);
            else                                rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 200);
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
